// File: rtl/mult_pkg.sv
// mult_pkg: shared FSM encoding and sizing helper for the sequential multiplier.
package mult_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    // One extra bit keeps terminal count N-1 representable for any N, including powers of two.
    function automatic int cnt_w(int n);
        return $clog2(n) + 1;
    endfunction
endpackage

// File: rtl/mult_seq_ctrl_if.sv
// mult_seq_ctrl_if: two-requester multiply request/grant bus with result return.
interface mult_seq_ctrl_if #(parameter int N = 4);
    logic req0, req1, gnt0, gnt1, busy, done, owner;
    logic [N-1:0] a0, b0, a1, b1;
    logic [2*N-1:0] result;
    modport master(output req0, req1, a0, b0, a1, b1, input gnt0, gnt1, busy, done, owner, result);
    modport slave(input req0, req1, a0, b0, a1, b1, output gnt0, gnt1, busy, done, owner, result);
endinterface

// File: rtl/mult_seq_ctrl_rr_arb2.sv
// rr_arb2: two-way round-robin picker; on a tie the requester not granted last wins.
module rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic idx,
    output logic vld
);
    assign vld = req0 | req1;
    assign idx = (req0 & req1) ? ~last : req1;
endmodule

// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: shift-and-add multiplier shared by two requesters, one operand bit per RUN cycle.
module mult_seq_ctrl import mult_pkg::*; #(
    parameter int N = 4
) (
    input logic clk,
    input logic rst,
    mult_seq_ctrl_if.slave bus
);
    localparam int CW = cnt_w(N);
    localparam int W = 2 * N;
    state_t state, state_nxt;
    logic [W-1:0] acc, acc_nxt, ma;
    logic [N-1:0] mb;
    logic [CW-1:0] cnt;
    logic last, sel, vld, take, term;
    rr_arb2 u_arb (.req0(bus.req0), .req1(bus.req1), .last(last), .idx(sel), .vld(vld));
    // Grants are suppressed while reset is held so a pending request is arbitrated only after release.
    assign take = !rst && state == IDLE && vld;
    assign bus.gnt0 = take && !sel;
    assign bus.gnt1 = take && sel;
    assign bus.busy = state != IDLE;
    assign bus.done = state == DONE;
    assign term = cnt == CW'(N - 1);
    // ma/mb walk the operands so iteration i adds (a << i) when b[i] is set.
    assign acc_nxt = acc + (mb[0] ? ma : '0);
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_nxt;
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: state_nxt = vld ? RUN : IDLE;
            RUN: state_nxt = term ? DONE : RUN;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            cnt <= '0;
            ma <= '0;
            mb <= '0;
            last <= 1'b1;
            bus.owner <= 1'b0;
            bus.result <= '0;
        end else if (take) begin
            acc <= '0;
            cnt <= '0;
            ma <= W'(sel ? bus.a1 : bus.a0);
            mb <= sel ? bus.b1 : bus.b0;
            last <= sel;
            bus.owner <= sel;
        end else if (state == RUN) begin
            acc <= acc_nxt;
            cnt <= cnt + CW'(1);
            ma <= ma << 1;
            mb <= mb >> 1;
            if (term) bus.result <= acc_nxt;
        end
    end
endmodule

// File: tb/tb_mult_seq_ctrl.sv
// tb_mult_seq_ctrl: directed and random checks of N=4 and N=8 instances against a cycle-level product model.
module tb_mult_seq_ctrl;
    logic clk = 0;
    logic rst = 1;
    int checks = 0;
    int errors = 0;
    bit rq [2][2];
    logic [7:0] ra [2][2];
    logic [7:0] rb [2][2];
    logic [20:0] obs [2];
    int cnt [2];
    int ndone [2];
    bit last [2] = '{1'b1, 1'b1};
    bit eown [2];
    bit gseen [2][2];
    logic [15:0] eres [2];
    logic [15:0] prod [2];

    always #5 clk = ~clk;

    mult_seq_ctrl_if #(.N(4)) bus4 ();
    mult_seq_ctrl_if #(.N(8)) bus8 ();
    mult_seq_ctrl #(.N(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    mult_seq_ctrl #(.N(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

    assign bus4.req0 = rq[0][0];
    assign bus4.req1 = rq[0][1];
    assign bus4.a0 = ra[0][0][3:0];
    assign bus4.b0 = rb[0][0][3:0];
    assign bus4.a1 = ra[0][1][3:0];
    assign bus4.b1 = rb[0][1][3:0];
    assign bus8.req0 = rq[1][0];
    assign bus8.req1 = rq[1][1];
    assign bus8.a0 = ra[1][0];
    assign bus8.b0 = rb[1][0];
    assign bus8.a1 = ra[1][1];
    assign bus8.b1 = rb[1][1];
    // {gnt1, gnt0, busy, done, owner, result[15:0]}
    assign obs[0] = {bus4.gnt1, bus4.gnt0, bus4.busy, bus4.done, bus4.owner, 8'd0, bus4.result};
    assign obs[1] = {bus8.gnt1, bus8.gnt0, bus8.busy, bus8.done, bus8.owner, bus8.result};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: an accepted op produces done and a*b exactly N+1 cycles after its grant; no grant while one is in flight.
    task automatic model_step(input int id, input int n);
        logic [31:0] exp;
        bit idx, any;
        string tag;
        tag = id == 0 ? "mon4" : "mon8";
        if (rst) begin
            cnt[id] = 0;
            last[id] = 1'b1;
            eown[id] = 1'b0;
            eres[id] = '0;
            chk(tag, 32'(obs[id]), 32'd0);
        end else if (cnt[id] == 0) begin
            any = rq[id][0] | rq[id][1];
            idx = (rq[id][0] && rq[id][1]) ? !last[id] : rq[id][1];
            exp = {11'd0, any ? (idx ? 2'b10 : 2'b01) : 2'b00, 2'b00, eown[id], eres[id]};
            chk(tag, 32'(obs[id]), exp);
            if (any) begin
                prod[id] = 16'(ra[id][idx]) * 16'(rb[id][idx]);
                eown[id] = idx;
                last[id] = idx;
                cnt[id] = n + 1;
            end
        end else begin
            if (cnt[id] == 1) begin
                eres[id] = prod[id];
                ndone[id]++;
            end
            exp = {11'd0, 2'b00, 1'b1, cnt[id] == 1, eown[id], eres[id]};
            chk(tag, 32'(obs[id]), exp);
            cnt[id]--;
        end
        gseen[id][0] = obs[id][19];
        gseen[id][1] = obs[id][20];
    endtask

    always @(negedge clk) begin
        model_step(0, 4);
        model_step(1, 8);
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(input int id, output int r, output int t);
        r = -1;
        t = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (obs[id][19] | obs[id][20]) begin
                r = int'(obs[id][20]);
                t = int'($time / 10);
                return;
            end
        end
        chk("gnt_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done(input int id, output int t, output logic [15:0] res, output bit own);
        t = 0;
        res = '0;
        own = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (obs[id][17]) begin
                t = int'($time / 10);
                res = obs[id][15:0];
                own = obs[id][16];
                return;
            end
        end
        chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic rand_cycle(input int id, input int n);
        logic [7:0] mask;
        mask = 8'((1 << n) - 1);
        for (int r = 0; r < 2; r++) begin
            if (rq[id][r] && gseen[id][r]) rq[id][r] = 1'b0;
            if (!rq[id][r]) begin
                ra[id][r] = $urandom_range(0, 7) == 0 ? mask : 8'($urandom) & mask;
                rb[id][r] = $urandom_range(0, 7) == 0 ? mask : 8'($urandom) & mask;
                rq[id][r] = $urandom_range(0, 2) == 0;
            end else if ($urandom_range(0, 15) == 0) rq[id][r] = 1'b0;
        end
    endtask

    initial begin
        int r, t0, t1, tp;
        logic [15:0] res;
        bit own;
        logic [7:0] za [3];
        logic [7:0] zb [3];
        za = '{8'd0, 8'd15, 8'd0};
        zb = '{8'd0, 8'd0, 8'd15};
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                ra[i][j] = '0;
                rb[i][j] = '0;
            end
        repeat (2) step;
        chk("rst_state", 32'(obs[0]), 32'd0);
        rst = 0;
        step;
        // 13 x 11 from requester 0; operands scrambled after the grant edge
        ra[0][0] = 13;
        rb[0][0] = 11;
        rq[0][0] = 1;
        wait_gnt(0, r, t0);
        chk("r028_gnt", r, 0);
        step;
        rq[0][0] = 0;
        ra[0][0] = 8'd2;
        rb[0][0] = 8'd7;
        wait_done(0, t1, res, own);
        chk("r028_lat", t1 - t0, 5);
        chk("r028_res", 32'(res), 32'd143);
        chk("r028_own", 32'(own), 32'd0);
        step;
        // simultaneous requests straight out of reset
        rst = 1;
        step;
        rst = 0;
        ra[0][0] = 3;
        rb[0][0] = 5;
        ra[0][1] = 15;
        rb[0][1] = 15;
        rq[0][0] = 1;
        rq[0][1] = 1;
        wait_gnt(0, r, t0);
        chk("r029_first", r, 0);
        step;
        rq[0][0] = 0;
        wait_done(0, t1, res, own);
        chk("r029_res0", 32'(res), 32'd15);
        chk("r029_own0", 32'(own), 32'd0);
        wait_gnt(0, r, t1);
        chk("r029_second", r, 1);
        chk("r029_gap", t1 - t0, 6);
        step;
        rq[0][1] = 0;
        wait_done(0, t1, res, own);
        chk("r029_res1", 32'(res), 32'd225);
        chk("r029_own1", 32'(own), 32'd1);
        step;
        // both held continuously: strict alternation at full throughput
        ra[0][0] = 7;
        rb[0][0] = 2;
        ra[0][1] = 5;
        rb[0][1] = 3;
        rq[0][0] = 1;
        rq[0][1] = 1;
        tp = 0;
        for (int i = 0; i < 4; i++) begin
            wait_gnt(0, r, t0);
            chk("r030_order", r, i % 2);
            if (i > 0) chk("r030_gap", t0 - tp, 6);
            tp = t0;
        end
        step;
        rq[0][0] = 0;
        rq[0][1] = 0;
        repeat (8) step;
        // reset in the second RUN cycle of 9 x 9 with the request left pending
        ra[0][0] = 9;
        rb[0][0] = 9;
        rq[0][0] = 1;
        wait_gnt(0, r, t0);
        step;
        step;
        rst = 1;
        #1;
        chk("r032_zero", 32'(obs[0]), 32'd0);
        step;
        rst = 0;
        wait_gnt(0, r, t0);
        chk("r032_regnt", r, 0);
        step;
        rq[0][0] = 0;
        wait_done(0, t1, res, own);
        chk("r032_lat", t1 - t0, 5);
        chk("r032_res", 32'(res), 32'd81);
        step;
        // zero operands still take the full latency
        for (int k = 0; k < 3; k++) begin
            ra[0][0] = za[k];
            rb[0][0] = zb[k];
            rq[0][0] = 1;
            wait_gnt(0, r, t0);
            step;
            rq[0][0] = 0;
            wait_done(0, t1, res, own);
            chk("r031_lat", t1 - t0, 5);
            chk("r031_res", 32'(res), 32'd0);
            step;
        end
        // random traffic on both instances; the negedge model checks every cycle
        rst = 1;
        step;
        rst = 0;
        ndone[1] = 0;
        for (int c = 0; c < 60000 && ndone[1] < 1000; c++) begin
            rand_cycle(0, 4);
            rand_cycle(1, 8);
            step;
        end
        chk("r033_ops", 32'(ndone[1] >= 1000), 32'd1);
        for (int i = 0; i < 2; i++) begin
            rq[i][0] = 0;
            rq[i][1] = 0;
        end
        repeat (12) step;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
